// File: rtl/dtw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dtw_pkg                                                      |
// | Description : Shared constants and types for the DTW result path.          |
// |               DTW_AXI_DWIDTH - stream word width of dtw_core               |
// |               DTW_DWIDTH     - internal DTW sample width                   |
// |               dtw_state_e    - result sink control states                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dtw_pkg;

    localparam int DTW_AXI_DWIDTH = 32;
    localparam int DTW_DWIDTH     = 16;

    typedef enum logic [0:0] {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } dtw_state_e;

endpackage
`default_nettype wire

// File: rtl/dtw_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dtw_sync_fifo                                                |
// | Description : Single-clock FIFO storage, combinational read of the head.   |
// |               clk, rst_n : clock, async active-low reset                   |
// |               push, din  : write strobe and data                           |
// |               pop, dout  : read strobe and head-of-queue data              |
// |               count      : stored entries (0..DEPTH)                       |
// |               The caller never pushes when full nor pops when empty.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dtw_sync_fifo
    import dtw_pkg::*;
#(
    parameter int DWIDTH = DTW_AXI_DWIDTH,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DWIDTH-1:0]        din,
    output logic [DWIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);

    // Data array carries no reset; validity is tracked by the pointers.
    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/dtw_result_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dtw_result_sink                                              |
// | Description : Buffers dtw_core result words and replays them as an         |
// |               AXI-Stream with packet framing (tlast every pkt_len beats).  |
// |               sink_fifo_wren/data/full : write side from dtw_core          |
// |               pkt_len                  : beats per packet, latched per pkt |
// |               m_axis_*                 : stream output (FWFT, 1-cycle lat.)|
// |               level                    : occupancy incl. output register   |
// |               overflow                 : sticky, write seen while full     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dtw_result_sink
    import dtw_pkg::*;
#(
    parameter int DWIDTH = DTW_AXI_DWIDTH,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sink_fifo_wren,
    output logic                     sink_fifo_full,
    input  logic [DWIDTH-1:0]        sink_fifo_data,
    input  logic [31:0]              pkt_len,
    output logic [DWIDTH-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int              c_LW         = $clog2(DEPTH) + 1;
    localparam logic [0:0]      c_ST_EMPTY   = EMPTY;
    localparam logic [0:0]      c_ST_STREAM  = STREAM;
    localparam logic [c_LW-1:0] c_FULL_LEVEL = c_LW'(DEPTH);

    logic [0:0]        r_state;
    logic [DWIDTH-1:0] r_tdata;
    logic              r_tlast;
    logic              r_full;
    logic              r_overflow;
    logic [c_LW-1:0]   r_level;
    logic [31:0]       r_beat_cnt;
    logic [31:0]       r_len;
    logic              r_run;

    logic              w_push_ok;
    logic              w_xfer;
    logic              w_out_free;
    logic              w_fifo_empty;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic              w_load;
    logic [DWIDTH-1:0] w_fifo_dout;
    logic [DWIDTH-1:0] w_load_data;
    logic [c_LW-1:0]   w_fifo_count;
    logic [c_LW-1:0]   w_level_next;
    logic [31:0]       w_next_idx;
    logic [31:0]       w_len_eff;
    logic              w_next_last;

    // r_run stays low for the first edge after reset release so a write
    // presented as reset lifts is not taken.
    assign w_push_ok    = sink_fifo_wren & ~r_full & r_run;
    assign w_xfer       = (r_state == c_ST_STREAM) & m_axis_tready;
    assign w_out_free   = (r_state == c_ST_EMPTY) | w_xfer;
    assign w_fifo_empty = (w_fifo_count == '0);

    // The output register refills from the FIFO head first; an incoming word
    // bypasses the FIFO only when the FIFO holds nothing older.
    assign w_fifo_pop   = w_out_free & ~w_fifo_empty;
    assign w_fifo_push  = w_push_ok & ~(w_out_free & w_fifo_empty);
    assign w_load       = w_out_free & (~w_fifo_empty | w_push_ok);
    assign w_load_data  = w_fifo_empty ? sink_fifo_data : w_fifo_dout;

    // Beat index of the word about to enter the output register.
    assign w_next_idx   = w_xfer ? (r_tlast ? 32'd0 : r_beat_cnt + 32'd1) : r_beat_cnt;
    // The first beat of a packet uses the live pkt_len; later beats use the
    // value latched with that first beat.
    assign w_len_eff    = (w_next_idx == 32'd0) ? pkt_len : r_len;
    assign w_next_last  = (w_len_eff <= 32'd1) | (w_next_idx == w_len_eff - 32'd1);

    always_comb begin
        w_level_next = r_level;
        case ({w_push_ok, w_xfer})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    dtw_sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (w_fifo_push),
        .pop    (w_fifo_pop),
        .din    (sink_fifo_data),
        .dout   (w_fifo_dout),
        .count  (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_EMPTY;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_level    <= '0;
            r_beat_cnt <= '0;
            r_len      <= '0;
            r_run      <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_level    <= w_level_next;
            r_full     <= (w_level_next == c_FULL_LEVEL);
            r_overflow <= r_overflow | (sink_fifo_wren & r_full);

            if (w_xfer) begin
                r_beat_cnt <= r_tlast ? 32'd0 : r_beat_cnt + 32'd1;
            end

            if (w_load) begin
                r_state <= c_ST_STREAM;
                r_tdata <= w_load_data;
                r_tlast <= w_next_last;
                if (w_next_idx == 32'd0) begin
                    r_len <= pkt_len;
                end
            end else if (w_xfer) begin
                r_state <= c_ST_EMPTY;
                r_tlast <= 1'b0;
            end
        end
    end

    assign sink_fifo_full = r_full;
    assign m_axis_tdata   = r_tdata;
    assign m_axis_tvalid  = (r_state == c_ST_STREAM);
    assign m_axis_tlast   = r_tlast;
    assign level          = r_level;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dtw_result_sink.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_dtw_result_sink                                           |
// | Description : Scoreboard bench for dtw_result_sink. Written words are      |
// |               queued; every stream beat is popped and compared, tlast is   |
// |               predicted from an independent packet model.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dtw_result_sink;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    typedef logic [DW-1:0] word_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wren    = 1'b0;
    word_t         wdata   = '0;
    logic [31:0]   pkt_len = 32'd1;
    logic          tready  = 1'b0;
    logic          full;
    word_t         tdata;
    logic          tvalid;
    logic          tlast;
    logic [LW-1:0] level;
    logic          overflow;

    dtw_result_sink #(
        .DWIDTH (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sink_fifo_wren (wren),
        .sink_fifo_full (full),
        .sink_fifo_data (wdata),
        .pkt_len        (pkt_len),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tlast   (tlast),
        .level          (level),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_rx     = 0;
    word_t       exp_q[$];
    logic [31:0] m_beat   = 32'd0;
    logic [31:0] m_len    = 32'd0;
    logic        m_exp_last;
    word_t       m_exp_data;
    logic        prev_stall = 1'b0;
    word_t       prev_data;
    logic        prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: samples on the falling edge, a beat is a transfer that
    // the following rising edge will commit.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_beat     = 32'd0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", tvalid, 1);
                check("hold_data",  tdata,  prev_data);
                check("hold_last",  tlast,  prev_last);
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            if (tvalid && tready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    m_exp_data = exp_q.pop_front();
                    check("tdata", tdata, m_exp_data);
                end
                if (m_beat == 32'd0) m_len = pkt_len;
                m_exp_last = (m_len <= 32'd1) || (m_beat == m_len - 32'd1);
                check("tlast", tlast, m_exp_last);
                m_beat = m_exp_last ? 32'd0 : m_beat + 32'd1;
                n_rx++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        wren   = 1'b0;
        tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic wr(input word_t d);
        wren  = 1'b1;
        wdata = d;
        if (!full) exp_q.push_back(d);
        tick();
        wren = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 300;
        tready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_level0"}, level, 0);
        check({tag, "_valid0"}, tvalid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0;

        // Reset state
        do_reset();
        check("rst_tvalid",   tvalid,   0);
        check("rst_full",     full,     0);
        check("rst_level",    level,    0);
        check("rst_overflow", overflow, 0);
        check("rst_tlast",    tlast,    0);
        check("rst_tdata",    tdata,    0);

        // Single word, one-cycle latency
        pkt_len = 32'd1;
        tready  = 1'b1;
        wr(32'h0000_00AA);
        check("single_tvalid", tvalid, 1);
        check("single_tdata",  tdata,  32'hAA);
        check("single_tlast",  tlast,  1);
        check("single_level",  level,  1);
        tick();
        check("single_tvalid_after", tvalid, 0);
        check("single_level_after",  level,  0);

        // Fill to full, overflow, drain in order
        tready  = 1'b0;
        pkt_len = 32'd4;
        for (int i = 0; i < 16; i++) begin
            check("fill_not_full", full, 0);
            wr(word_t'(i));
        end
        check("fill_full",     full,     1);
        check("fill_level",    level,    16);
        check("fill_ovf_pre",  overflow, 0);
        wr(32'd16);
        check("fill_ovf_set",  overflow, 1);
        check("fill_level_17", level,    16);
        drain("fill");
        check("fill_ovf_sticky", overflow, 1);
        do_reset();
        check("ovf_cleared", overflow, 0);

        // Packets of 4: 10 words then 2 more closes the third packet
        pkt_len = 32'd4;
        tready  = 1'b1;
        for (int i = 0; i < 10; i++) wr(32'h100 + word_t'(i));
        drain("pkt10");
        for (int i = 0; i < 2; i++) wr(32'h200 + word_t'(i));
        drain("pkt12");

        // Mid-packet pkt_len change only applies to the next packet
        for (int i = 0; i < 6; i++) begin
            if (i == 2) pkt_len = 32'd2;
            wr(32'h300 + word_t'(i));
        end
        drain("lenchg");

        // pkt_len 0: every beat is last
        pkt_len = 32'd0;
        for (int i = 0; i < 3; i++) wr(32'h400 + word_t'(i));
        drain("len0");

        // Random backpressure, full-rate writes honouring full
        pkt_len = 32'd7;
        rx0     = n_rx;
        for (int i = 0; i < 1000; ) begin
            tready = 1'($urandom_range(0, 1));
            if (!full) begin
                wren  = 1'b1;
                wdata = $urandom;
                exp_q.push_back(wdata);
                i++;
            end else begin
                wren = 1'b0;
            end
            tick();
        end
        wren = 1'b0;
        drain("bp");
        check("bp_rx_count", n_rx - rx0, 1000);
        check("bp_overflow", overflow, 0);

        // Simultaneous write and transfer at level 8
        tready = 1'b0;
        for (int i = 0; i < 8; i++) wr(32'h500 + word_t'(i));
        check("sim_level_start", level, 8);
        for (int i = 0; i < 20; i++) begin
            tready = 1'b1;
            wr(32'h600 + word_t'(i));
            check("sim_level", level, 8);
        end
        drain("sim");

        // Asynchronous reset mid-packet while full
        pkt_len = 32'd4;
        tready  = 1'b1;
        wr(32'h700);
        wr(32'h701);
        tready = 1'b0;
        for (int i = 0; i < 15; i++) wr(32'h710 + word_t'(i));
        check("ar_full_pre", full, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_tvalid", tvalid, 0);
        check("ar_full",   full,   0);
        check("ar_level",  level,  0);
        check("ar_tlast",  tlast,  0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("ar_ovf", overflow, 0);
        tready = 1'b1;
        for (int i = 0; i < 4; i++) wr(32'h800 + word_t'(i));
        drain("ar_pkt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
